// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq_ctrl sequencer: opcodes, IR field positions,
// state encoding, opcode classification and ALU op-select decode.
package alu_seq_pkg;

  // IR field bit positions
  localparam int unsigned OpcMsb = 31;
  localparam int unsigned OpcLsb = 27;
  localparam int unsigned RaMsb  = 26;
  localparam int unsigned RaLsb  = 23;
  localparam int unsigned RbMsb  = 22;
  localparam int unsigned RbLsb  = 19;
  localparam int unsigned RcMsb  = 18;
  localparam int unsigned RcLsb  = 15;

  localparam int unsigned RegSelW = 4;

  // Opcodes
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpShr  = 5'b01001;
  localparam logic [4:0] OpShra = 5'b01010;
  localparam logic [4:0] OpShl  = 5'b01011;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;

  // Bit positions inside the ALU op-select vector
  localparam int unsigned NumAluOps = 13;
  localparam int unsigned SelAdd  = 0;
  localparam int unsigned SelSub  = 1;
  localparam int unsigned SelAnd  = 2;
  localparam int unsigned SelOr   = 3;
  localparam int unsigned SelShr  = 4;
  localparam int unsigned SelShra = 5;
  localparam int unsigned SelShl  = 6;
  localparam int unsigned SelRor  = 7;
  localparam int unsigned SelRol  = 8;
  localparam int unsigned SelNeg  = 9;
  localparam int unsigned SelNot  = 10;
  localparam int unsigned SelMul  = 11;
  localparam int unsigned SelDiv  = 12;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT4u
  } state_e;

  typedef enum logic [1:0] {
    ClsIllegal, ClsBinary, ClsMulDiv, ClsUnary
  } op_cls_e;

  function automatic op_cls_e op_class(input logic [4:0] opc);
    op_cls_e cls;
    case (opc)
      OpAdd, OpSub, OpAnd, OpOr, OpRor, OpRol, OpShr, OpShra, OpShl: cls = ClsBinary;
      OpMul, OpDiv:                                                 cls = ClsMulDiv;
      OpNeg, OpNot:                                                 cls = ClsUnary;
      default:                                                      cls = ClsIllegal;
    endcase
    return cls;
  endfunction

  function automatic logic [NumAluOps-1:0] op_select(input logic [4:0] opc);
    logic [NumAluOps-1:0] sel;
    sel = '0;
    case (opc)
      OpAdd:   sel[SelAdd]  = 1'b1;
      OpSub:   sel[SelSub]  = 1'b1;
      OpAnd:   sel[SelAnd]  = 1'b1;
      OpOr:    sel[SelOr]   = 1'b1;
      OpShr:   sel[SelShr]  = 1'b1;
      OpShra:  sel[SelShra] = 1'b1;
      OpShl:   sel[SelShl]  = 1'b1;
      OpRor:   sel[SelRor]  = 1'b1;
      OpRol:   sel[SelRol]  = 1'b1;
      OpNeg:   sel[SelNeg]  = 1'b1;
      OpNot:   sel[SelNot]  = 1'b1;
      OpMul:   sel[SelMul]  = 1'b1;
      OpDiv:   sel[SelDiv]  = 1'b1;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register-number to one-hot strobe decoder with enable; all-zero when disabled.
module reg_onehot_dec
  import alu_seq_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [RegSelW-1:0] sel_i,
  input  logic               en_i,
  output logic [N-1:0]       onehot_o
);

  // Single bit set at sel_i when enabled
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o = {{(N-1){1'b0}}, 1'b1} << sel_i;
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Hardwired fetch/execute control sequencer for register ALU instructions.
// Optional build macro ALU_SEQ_CNT_EN adds the instr_cnt completed-instruction counter.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned NREGS = 16,
  parameter int unsigned IR_W  = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             mem_rdy,
  input  logic [IR_W-1:0]  IR,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic             ADD,
  output logic             SUB,
  output logic             AND,
  output logic             OR,
  output logic             SHR,
  output logic             SHRA,
  output logic             SHL,
  output logic             ROR,
  output logic             ROL,
  output logic             NEG,
  output logic             NOT,
  output logic             MUL,
  output logic             DIV
`ifdef ALU_SEQ_CNT_EN
  ,output logic [31:0]     instr_cnt
`endif
);

  state_e               state_d, state_q;
  logic [4:0]           opc_d, opc_q;
  logic [RegSelW-1:0]   ra_d, ra_q, rb_d, rb_q, rc_d, rc_q;
  logic                 rin_en, rout_en, alu_en;
  logic [RegSelW-1:0]   rin_sel, rout_sel;
  logic [NumAluOps-1:0] alu_sel;
  op_cls_e              cls;

  // Low IR bits carry no register field for this instruction class
  logic unused_ir;
  assign unused_ir = ^IR[RcLsb-1:0];

  assign cls     = op_class(opc_q);
  assign busy    = (state_q != StIdle);
  assign alu_sel = alu_en ? op_select(opc_q) : '0;

  // Next state, field latching and per-state strobes
  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    done     = 1'b0;
    illegal  = 1'b0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    rin_en   = 1'b0;
    rin_sel  = ra_q;
    rout_en  = 1'b0;
    rout_sel = rb_q;
    alu_en   = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StT0;
      StT0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        // Read/MDRin stay up through the stall; PC only reloads once memory is ready
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_rdy) begin
          PCin    = 1'b1;
          state_d = StT2;
        end
      end
      StT2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        opc_d   = IR[OpcMsb:OpcLsb];
        ra_d    = IR[RaMsb:RaLsb];
        rb_d    = IR[RbMsb:RbLsb];
        rc_d    = IR[RcMsb:RcLsb];
        state_d = StT3;
      end
      StT3: begin
        unique case (cls)
          ClsIllegal: begin
            illegal = 1'b1;
            state_d = StIdle;
          end
          ClsUnary: begin
            rout_en  = 1'b1;
            rout_sel = rc_q;
            alu_en   = 1'b1;
            Zin      = 1'b1;
            state_d  = StT4u;
          end
          default: begin
            rout_en  = 1'b1;
            rout_sel = rb_q;
            Yin      = 1'b1;
            state_d  = StT4;
          end
        endcase
      end
      StT4: begin
        rout_en  = 1'b1;
        rout_sel = rc_q;
        alu_en   = 1'b1;
        Zin      = 1'b1;
        state_d  = StT5;
      end
      StT5: begin
        Zlowout = 1'b1;
        if (cls == ClsMulDiv) begin
          LOin    = 1'b1;
          state_d = StT6;
        end else begin
          rin_en  = 1'b1;
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      StT6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
        state_d  = StIdle;
      end
      StT4u: begin
        Zlowout = 1'b1;
        rin_en  = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched IR fields
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
      opc_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
    end
  end

  reg_onehot_dec #(.N(NREGS)) u_rin_dec (
    .sel_i    (rin_sel),
    .en_i     (rin_en),
    .onehot_o (Rin)
  );

  reg_onehot_dec #(.N(NREGS)) u_rout_dec (
    .sel_i    (rout_sel),
    .en_i     (rout_en),
    .onehot_o (Rout)
  );

  assign ADD  = alu_sel[SelAdd];
  assign SUB  = alu_sel[SelSub];
  assign AND  = alu_sel[SelAnd];
  assign OR   = alu_sel[SelOr];
  assign SHR  = alu_sel[SelShr];
  assign SHRA = alu_sel[SelShra];
  assign SHL  = alu_sel[SelShl];
  assign ROR  = alu_sel[SelRor];
  assign ROL  = alu_sel[SelRol];
  assign NEG  = alu_sel[SelNeg];
  assign NOT  = alu_sel[SelNot];
  assign MUL  = alu_sel[SelMul];
  assign DIV  = alu_sel[SelDiv];

`ifdef ALU_SEQ_CNT_EN
  logic [31:0] cnt_d, cnt_q;

  // Count completed instructions; illegal opcodes never reach done
  always_comb cnt_d = cnt_q + {31'd0, done};

  // Counter register, cleared with the sequencer
  always_ff @(posedge clock or posedge clear) begin
    if (clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign instr_cnt = cnt_q;
`endif

endmodule
